// File: rtl/ita_act_packer_pkg.sv
// Shared constants and types for the ITA activation output packer.
package ita_act_packer_pkg;

  // Default lane count (one lane per PE) and activation output width.
  localparam int unsigned N_PE = 16;
  localparam int unsigned WO   = 8;

  // Completed-word buffer depth; fixed at 2 in this revision.
  localparam int unsigned ACT_PACK_FIFO_DEPTH = 2;

  // Packed activation word at the default geometry; lane k is element k.
  typedef logic signed [N_PE-1:0][WO-1:0] act_word_t;

  // Width of one buffered entry: packed data, lane strobes and the tile-last flag.
  function automatic int unsigned act_entry_width(input int unsigned lanes,
                                                  input int unsigned elem_w);
    return lanes * elem_w + lanes + 1;
  endfunction

endpackage : ita_act_packer_pkg

// File: rtl/ita_act_fifo.sv
// Two-entry synchronous FIFO holding completed packed words.
// The head entry is presented directly from storage, so it holds steady until popped.
module ita_act_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  // Qualify requests so an overflowing push or underflowing pop is ignored.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Storage, pointers and occupancy update; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule : ita_act_fifo

// File: rtl/ita_act_packer.sv
// Collects the serial activation stream into N-lane words and hands them out
// through a two-word buffer on a valid/ready interface.
module ita_act_packer
  import ita_act_packer_pkg::*;
#(
  parameter int unsigned N          = N_PE,
  parameter int unsigned DATA_W     = WO,
  parameter int unsigned FIFO_DEPTH = ACT_PACK_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     last_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [N*DATA_W-1:0]      data_o,
  output logic [N-1:0]             strb_o,
  output logic                     last_o,
  output logic [15:0]              word_cnt_o
);

  localparam int unsigned LANE_W = $clog2(N);
  localparam int unsigned WORD_W = N * DATA_W;
  localparam int unsigned ENTRY_W = act_entry_width(N, DATA_W);

  // Elaboration guard on the supported geometry.
  if (FIFO_DEPTH != 2 || N < 2) begin : g_param_chk
    $error("ita_act_packer: unsupported FIFO_DEPTH or N");
  end

  logic [LANE_W-1:0]             lane_cnt;
  logic [N-1:0][DATA_W-1:0]      acc;
  logic [N-1:0]                  strb;
  logic [N-1:0][DATA_W-1:0]      acc_fill;
  logic [N-1:0]                  strb_fill;
  logic                          accept;
  logic                          close;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          pop;
  logic [ENTRY_W-1:0]            push_entry;
  logic [ENTRY_W-1:0]            head_entry;

  // Input acceptance depends only on registered buffer state.
  assign ready_o = !fifo_full;
  assign valid_o = !fifo_empty;
  assign pop     = valid_o && ready_i;

  // Accumulator and strobe as they look with the current element merged in.
  always_comb begin
    accept              = valid_i && ready_o;
    close               = accept && (last_i || (lane_cnt == LANE_W'(N - 1)));
    acc_fill            = acc;
    acc_fill[lane_cnt]  = data_i;
    strb_fill           = strb | (N'(1) << lane_cnt);
    push_entry          = {WORD_W'(acc_fill), strb_fill, last_i};
  end

  // Packing state: fill one lane per accepted element, clear when the word closes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_cnt <= '0;
      acc      <= '0;
      strb     <= '0;
    end else if (accept) begin
      if (close) begin
        lane_cnt <= '0;
        acc      <= '0;
        strb     <= '0;
      end else begin
        lane_cnt <= lane_cnt + LANE_W'(1);
        acc      <= acc_fill;
        strb     <= strb_fill;
      end
    end
  end

  // Count of completed output handshakes, wrapping at 2^16.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_cnt_o <= 16'd0;
    end else if (pop) begin
      word_cnt_o <= word_cnt_o + 16'd1;
    end
  end

  ita_act_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (close),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign data_o = head_entry[ENTRY_W-1 -: WORD_W];
  assign strb_o = head_entry[N:1];
  assign last_o = head_entry[0];

endmodule : ita_act_packer

// File: tb/tb_ita_act_packer.sv
// Directed bench for the activation packer with hand-computed expected words.
module tb_ita_act_packer;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 8;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [DW-1:0] data_i;
  logic               last_i;
  logic               valid_o;
  logic               ready_i;
  logic [N*DW-1:0]    data_o;
  logic [N-1:0]       strb_o;
  logic               last_o;
  logic [15:0]        word_cnt_o;

  int n_checks = 0;
  int n_bad    = 0;

  logic [N*DW-1:0] q_data [$];
  logic [N-1:0]    q_strb [$];
  logic            q_last [$];
  bit              cap_en = 1'b1;

  always #5 clk = ~clk;

  ita_act_packer dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .last_i     (last_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .strb_o     (strb_o),
    .last_o     (last_o),
    .word_cnt_o (word_cnt_o)
  );

  // Record every word that will complete a handshake at the coming edge.
  always @(negedge clk) begin
    if (cap_en && !rst_i && valid_o && ready_i) begin
      q_data.push_back(data_o);
      q_strb.push_back(strb_o);
      q_last.push_back(last_o);
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one element and hold it until it is accepted.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int guard = 0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    @(negedge clk);
    while (!ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) check_eq("send_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for the buffer to empty, bounded.
  task automatic drain();
    int guard = 0;
    while (valid_o && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (valid_o) check_eq("drain_timeout", 128'd0, 128'd1);
    idle(2);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [N*DW-1:0] ed,
                            input logic [N-1:0] es, input logic el);
    if (idx < q_data.size()) begin
      check_eq({tag, "_data"}, q_data[idx], ed);
      check_eq({tag, "_strb"}, 128'(q_strb[idx]), 128'(es));
      check_eq({tag, "_last"}, 128'(q_last[idx]), 128'(el));
    end else begin
      check_eq({tag, "_missing"}, 128'(q_data.size()), 128'(idx + 1));
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_strb.delete();
    q_last.delete();
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  logic [N*DW-1:0] exp_seq;
  logic [N*DW-1:0] exp_w;
  logic [N*DW-1:0] snap;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    last_i  = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    check_eq("rst_valid", 128'(valid_o), 128'd0);
    check_eq("rst_data", data_o, 128'd0);
    check_eq("rst_strb", 128'(strb_o), 128'd0);
    check_eq("rst_last", 128'(last_o), 128'd0);
    check_eq("rst_cnt", 128'(word_cnt_o), 128'd0);
    check_eq("rst_ready", 128'(ready_o), 128'd1);

    // Full tile 1..16: word appears the cycle after the closing edge, for one cycle.
    exp_seq = '0;
    for (int k = 0; k < 16; k++) exp_seq[k*DW +: DW] = DW'(k + 1);
    for (int k = 1; k <= 16; k++) send(DW'(k), k == 16);
    check_eq("t1_valid", 128'(valid_o), 128'd1);
    check_eq("t1_data", data_o, exp_seq);
    check_eq("t1_strb", 128'(strb_o), 128'hFFFF);
    check_eq("t1_last", 128'(last_o), 128'd1);
    @(posedge clk);
    #1;
    check_eq("t1_valid_gone", 128'(valid_o), 128'd0);
    check_eq("t1_cnt", 128'(word_cnt_o), 128'd1);
    idle(1);
    clear_q();

    // Short tile of 5 signed values closed early by last.
    send(8'hFD, 1'b0);
    send(8'hFE, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    send(8'h7F, 1'b1);
    drain();
    exp_w = '0;
    exp_w[7:0]   = 8'hFD;
    exp_w[15:8]  = 8'hFE;
    exp_w[23:16] = 8'hFF;
    exp_w[31:24] = 8'h00;
    exp_w[39:32] = 8'h7F;
    check_word("t2", 0, exp_w, 16'h001F, 1'b1);
    check_eq("t2_cnt", 128'(word_cnt_o), 128'd2);
    clear_q();

    // Backpressure: two words fill the buffer, the third waits for release.
    ready_i = 1'b0;
    for (int i = 1; i <= 32; i++) send(DW'(i), 1'b0);
    check_eq("t3_ready_full", 128'(ready_o), 128'd0);
    check_eq("t3_valid_full", 128'(valid_o), 128'd1);
    check_eq("t3_head", data_o, exp_seq);
    snap = data_o;
    repeat (5) @(posedge clk);
    #1;
    check_eq("t3_stable", data_o, snap);
    check_eq("t3_stable_strb", 128'(strb_o), 128'hFFFF);
    check_eq("t3_ready_still0", 128'(ready_o), 128'd0);
    ready_i = 1'b1;
    for (int i = 33; i <= 48; i++) send(DW'(i), i == 48);
    drain();
    check_eq("t3_nwords", 128'(q_data.size()), 128'd3);
    for (int w = 0; w < 3; w++) begin
      exp_w = '0;
      for (int k = 0; k < 16; k++) exp_w[k*DW +: DW] = DW'(w*16 + k + 1);
      check_word($sformatf("t3_w%0d", w), w, exp_w, 16'hFFFF, w == 2);
    end
    check_eq("t3_cnt", 128'(word_cnt_o), 128'd5);
    clear_q();

    // Gaps inside a tile do not close the word.
    for (int k = 1; k <= 3; k++) send(DW'(k), 1'b0);
    idle(2);
    for (int k = 4; k <= 10; k++) send(DW'(k), 1'b0);
    idle(3);
    for (int k = 11; k <= 16; k++) send(DW'(k), k == 16);
    drain();
    check_eq("t4_nwords", 128'(q_data.size()), 128'd1);
    check_word("t4", 0, exp_seq, 16'hFFFF, 1'b1);
    clear_q();

    // Reset with a partial word: partial discarded, fresh word starts at lane 0.
    for (int k = 0; k < 7; k++) send(DW'(8'h40 + k), 1'b0);
    pulse_reset();
    check_eq("t5a_valid", 128'(valid_o), 128'd0);
    check_eq("t5a_cnt", 128'(word_cnt_o), 128'd0);
    check_eq("t5a_ready", 128'(ready_o), 128'd1);
    exp_w = '0;
    for (int k = 0; k < 16; k++) exp_w[k*DW +: DW] = DW'(8'h20 + k);
    for (int k = 0; k < 16; k++) send(DW'(8'h20 + k), k == 15);
    drain();
    check_eq("t5a_nwords", 128'(q_data.size()), 128'd1);
    check_word("t5a", 0, exp_w, 16'hFFFF, 1'b1);
    clear_q();

    // Reset with one buffered word: the word is dropped.
    ready_i = 1'b0;
    for (int k = 0; k < 16; k++) send(DW'(8'h50 + k), k == 15);
    check_eq("t5b_buffered", 128'(valid_o), 128'd1);
    pulse_reset();
    check_eq("t5b_valid", 128'(valid_o), 128'd0);
    check_eq("t5b_cnt", 128'(word_cnt_o), 128'd0);
    check_eq("t5b_ready", 128'(ready_o), 128'd1);
    check_eq("t5b_data", data_o, 128'd0);
    ready_i = 1'b1;
    exp_w = '0;
    for (int k = 0; k < 16; k++) exp_w[k*DW +: DW] = DW'(8'h60 + k);
    for (int k = 0; k < 16; k++) send(DW'(8'h60 + k), k == 15);
    drain();
    check_eq("t5b_nwords", 128'(q_data.size()), 128'd1);
    check_word("t5b", 0, exp_w, 16'hFFFF, 1'b1);
    check_eq("t5b_cnt1", 128'(word_cnt_o), 128'd1);
    clear_q();

    // Word counter wrap: single-element tiles back to back.
    cap_en = 1'b0;
    for (int i = 0; i < 65534; i++) send(8'h05, 1'b1);
    drain();
    check_eq("t6_cnt_max", 128'(word_cnt_o), 128'hFFFF);
    send(8'h05, 1'b1);
    drain();
    check_eq("t6_cnt_wrap", 128'(word_cnt_o), 128'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule : tb_ita_act_packer
